// File: rtl/uart_packet_deframer.sv
// rtl/uart_packet_deframer.sv - byte-stream deframer: SYNC, Dest, Src, Length, payload -> UART_PACKET beats
// Optional inter-byte timeout is built when PACKET_TIMEOUT_EN is defined.
module uart_packet_deframer #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [34:0] opRxStream,
  output logic        opError
);

  typedef enum logic [2:0] {IDLE, DEST, SRC, LEN, DATA} stateT;

  stateT      state, nextState;
  logic [7:0] count, destination, source, length, data;
  logic       valid, sop, eop, error;
  logic       beat, lastBeat, errPulse, latchDest, latchSrc, latchLen;
  logic       timeoutHit;

  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef PACKET_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gapCount;

  // The gap that would make gapCount reach TIMEOUT_CYCLES is the one that aborts the frame.
  assign timeoutHit = (state != IDLE) && !ipRxValid &&
                      (gapCount == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ipClk) begin
    if (ipReset || ipRxValid || state == IDLE || timeoutHit) begin
      gapCount <= '0;
    end else begin
      gapCount <= gapCount + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    nextState = state;
    beat      = 1'b0;
    lastBeat  = 1'b0;
    errPulse  = 1'b0;
    latchDest = 1'b0;
    latchSrc  = 1'b0;
    latchLen  = 1'b0;
    if (ipRxValid) begin
      case (state)
        IDLE: if (ipRxData == SYNC_BYTE) nextState = DEST;
        DEST: begin
          latchDest = 1'b1;
          nextState = SRC;
        end
        SRC: begin
          latchSrc  = 1'b1;
          nextState = LEN;
        end
        LEN: begin
          if (ipRxData == 8'h00) begin
            errPulse  = 1'b1;
            nextState = IDLE;
          end else begin
            latchLen  = 1'b1;
            nextState = DATA;
          end
        end
        DATA: begin
          beat = 1'b1;
          if (count == 8'd1) begin
            lastBeat  = 1'b1;
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end else if (timeoutHit) begin
      errPulse  = 1'b1;
      nextState = IDLE;
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state       <= IDLE;
      count       <= '0;
      destination <= '0;
      source      <= '0;
      length      <= '0;
      data        <= '0;
      valid       <= 1'b0;
      sop         <= 1'b0;
      eop         <= 1'b0;
      error       <= 1'b0;
    end else begin
      state <= nextState;
      valid <= beat;
      // count still equals length only on the first payload byte
      sop   <= beat && (count == length);
      eop   <= lastBeat;
      error <= errPulse;
      if (latchDest) destination <= ipRxData;
      if (latchSrc)  source      <= ipRxData;
      if (latchLen) begin
        length <= ipRxData;
        count  <= ipRxData;
      end
      if (beat) begin
        data  <= ipRxData;
        count <= count - 8'd1;
      end
    end
  end

  assign opRxStream = {source, destination, length, sop, eop, data, valid};
  assign opError    = error;

endmodule

// File: tb/tb_uart_packet_deframer.sv
// tb/tb_uart_packet_deframer.sv - directed bench for uart_packet_deframer with a frame-position model
// Timeout scenario runs only when PACKET_TIMEOUT_EN is defined.
module tb_uart_packet_deframer;

  localparam int TMO = 100;

  logic        ipClk = 1'b0;
  logic        ipReset = 1'b1;
  logic [7:0]  ipRxData = 8'h00;
  logic        ipRxValid = 1'b0;
  logic [34:0] opRxStream;
  logic        opError;

  uart_packet_deframer #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TMO)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opRxStream(opRxStream), .opError(opError)
  );

  always #5 ipClk = ~ipClk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: position within the frame (0 hunting, 1 dest, 2 src, 3 len, 4 payload) plus payload index.
  int         mPos = 0, mIdx = 0, mGap = 0;
  logic [7:0] mDest = 0, mSrc = 0, mLen = 0, mData = 0;
  logic       mValid = 0, mSop = 0, mEop = 0, mErr = 0;

  always @(posedge ipClk) begin
    mValid = 0; mSop = 0; mEop = 0; mErr = 0;
    if (ipReset) begin
      mPos = 0; mIdx = 0; mGap = 0;
      mDest = 0; mSrc = 0; mLen = 0; mData = 0;
    end else if (ipRxValid) begin
      mGap = 0;
      if (mPos == 0) begin
        if (ipRxData == 8'h55) mPos = 1;
      end else if (mPos == 1) begin
        mDest = ipRxData; mPos = 2;
      end else if (mPos == 2) begin
        mSrc = ipRxData; mPos = 3;
      end else if (mPos == 3) begin
        if (ipRxData == 0) begin mErr = 1; mPos = 0; end
        else begin mLen = ipRxData; mIdx = 0; mPos = 4; end
      end else begin
        mValid = 1;
        mData  = ipRxData;
        mSop   = (mIdx == 0);
        mEop   = (mIdx == int'(mLen) - 1);
        mIdx++;
        if (mEop) mPos = 0;
      end
    end
`ifdef PACKET_TIMEOUT_EN
    else if (mPos != 0) begin
      mGap++;
      if (mGap == TMO) begin mErr = 1; mPos = 0; mGap = 0; end
    end
`endif
  end

  bit         armed = 0;
  int         errCount = 0;
  logic [7:0] logData[$];
  bit         logSop[$], logEop[$];

  always @(negedge ipClk) begin
    if (armed) begin
      check("stream", opRxStream, {mSrc, mDest, mLen, mSop, mEop, mData, mValid});
      check("opError", {34'd0, opError}, {34'd0, mErr});
      if (opRxStream[0]) begin
        logData.push_back(opRxStream[8:1]);
        logSop.push_back(opRxStream[10]);
        logEop.push_back(opRxStream[9]);
      end
      if (opError) errCount++;
    end
  end

  task automatic sendBytes(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      ipRxValid = 1'b1;
      ipRxData  = b[i];
      @(posedge ipClk); #1;
      ipRxValid = 1'b0;
      if (i != b.size() - 1) repeat (gap) begin @(posedge ipClk); #1; end
    end
    repeat (3) begin @(posedge ipClk); #1; end
  endtask

  task automatic clearLog();
    logData.delete(); logSop.delete(); logEop.delete();
  endtask

  // Expected beats with SoP/EoP flags packed as bit masks (bit i = beat i).
  task automatic checkBeats(input string name, input logic [7:0] d[$], input int sopMask, input int eopMask);
    check({name, "_count"}, 35'(logData.size()), 35'(d.size()));
    foreach (d[i]) begin
      if (i < logData.size()) begin
        check($sformatf("%s_data%0d", name, i), 35'(logData[i]), 35'(d[i]));
        check($sformatf("%s_sop%0d", name, i), 35'(logSop[i]), 35'((sopMask >> i) & 1));
        check($sformatf("%s_eop%0d", name, i), 35'(logEop[i]), 35'((eopMask >> i) & 1));
      end
    end
  endtask

  int errBefore;

  initial begin
    repeat (2) @(posedge ipClk);
    #1;
    ipReset = 1'b0;
    armed = 1;
    check("reset_stream", opRxStream, 35'd0);
    check("reset_error", {34'd0, opError}, 35'd0);

    clearLog();
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    checkBeats("t1", '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 'b0001, 'b1000);
    check("t1_hdr", 35'(opRxStream[34:11]), 35'({8'h01, 8'h00, 8'h04}));

    clearLog();
    sendBytes('{8'h12, 8'h34, 8'h55, 8'h02, 8'h07, 8'h01, 8'hAA}, 0);
    checkBeats("t2", '{8'hAA}, 'b1, 'b1);
    check("t2_hdr", 35'(opRxStream[34:11]), 35'({8'h07, 8'h02, 8'h01}));

    clearLog();
    errBefore = errCount;
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h00}, 0);
    check("t3_err_pulses", 35'(errCount - errBefore), 35'd1);
    check("t3_no_beats", 35'(logData.size()), 35'd0);
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h01, 8'h5A}, 0);
    checkBeats("t3b", '{8'h5A}, 'b1, 'b1);

    clearLog();
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h03, 8'h55, 8'h55, 8'h10}, 1);
    checkBeats("t4", '{8'h55, 8'h55, 8'h10}, 'b001, 'b100);

    clearLog();
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h04, 8'h11, 8'h22}, 0);
    ipReset = 1'b1;
    @(posedge ipClk); #1;
    ipReset = 1'b0;
    check("t5_reset_stream", opRxStream, 35'd0);
    check("t5_reset_error", {34'd0, opError}, 35'd0);
    sendBytes('{8'h55, 8'h03, 8'h04, 8'h02, 8'h33, 8'h44}, 0);
    checkBeats("t5", '{8'h11, 8'h22, 8'h33, 8'h44}, 'b0101, 'b1000);
    check("t5_hdr", 35'(opRxStream[34:11]), 35'({8'h04, 8'h03, 8'h02}));

`ifdef PACKET_TIMEOUT_EN
    clearLog();
    errBefore = errCount;
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h02}, 0);
    repeat (TMO) begin @(posedge ipClk); #1; end
    check("t6_timeout_err", 35'(errCount - errBefore), 35'd1);
    sendBytes('{8'h77}, 0);
    check("t6_no_beats", 35'(logData.size()), 35'd0);
    errBefore = errCount;
    sendBytes('{8'h55, 8'h00, 8'h01, 8'h02, 8'hA1, 8'hA2}, TMO - 1);
    check("t6_gap99_no_err", 35'(errCount - errBefore), 35'd0);
    checkBeats("t6", '{8'hA1, 8'hA2}, 'b01, 'b10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
